// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: component packing, bit reversal and
// the reorder buffer's read FSM states.
package fft_pkg;

    localparam int unsigned DBW_DEF  = 8;
    localparam int unsigned CBW_DEF  = 3;
    localparam int unsigned BR_MAXW  = 16;

    // Complex sample packing used on every FFT bus: imaginary high, real low.
    typedef struct packed {
        logic [DBW_DEF-1:0] im;
        logic [DBW_DEF-1:0] re;
    } cplx_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Reverse the low w bits of value; bits at and above w come back as zero.
    function automatic logic [BR_MAXW-1:0] bitrev(input logic [BR_MAXW-1:0] value,
                                                  input int unsigned w);
        logic [BR_MAXW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BR_MAXW; i++) begin
            if (i < w) r[i] = value[4'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module fft_reorder_ram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder_8.sv
// Bit-reversed to natural-order reorder buffer with ping-pong banks.
// Optional 1/N output normalisation under `FFT_REORDER_SCALE_EN.
module fft_reorder_8
    import fft_pkg::*;
#(
    parameter int unsigned DBW = DBW_DEF,
    parameter int unsigned CBW = CBW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*DBW-1:0] din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic [2*DBW-1:0] dout,
    output logic             dout_valid,
    output logic             dout_sof
);

    localparam int unsigned N  = 1 << CBW;
    localparam int unsigned AW = CBW + 1;
    localparam int unsigned DW = 2 * DBW;

    logic [CBW-1:0] wcnt;
    logic           wbank;
    logic [1:0]     full;
    logic [1:0]     full_nxt_c;
    logic [CBW-1:0] rcnt;
    logic           rbank;
    rd_state_t      state;

    logic [CBW-1:0] wpos_c;
    logic           wr_done_c;
    logic [AW-1:0]  waddr_c;
    logic           rd_go_c;
    logic           rd_done_c;
    logic [AW-1:0]  raddr_c;
    logic [DW-1:0]  rdata;
    logic           rd_vld;
    logic           rd_sof;
    logic [DW-1:0]  out_c;

    // A sof on a valid sample restarts the current bank at position 0.
    always_comb begin
        wpos_c     = din_sof ? '0 : wcnt;
        wr_done_c  = din_valid && (wpos_c == CBW'(N - 1));
        waddr_c    = {wbank, CBW'(bitrev(BR_MAXW'(wpos_c), CBW))};
        rd_go_c    = (state == READ) || full[rbank];
        rd_done_c  = rd_go_c && (rcnt == CBW'(N - 1));
        raddr_c    = {rbank, rcnt};
        full_nxt_c = full;
        if (rd_done_c) full_nxt_c[rbank] = 1'b0;
        if (wr_done_c) full_nxt_c[wbank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (din_valid) begin
            if (wr_done_c) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else begin
                wcnt <= wpos_c + 1'b1;
            end
        end
    end

    // Read FSM: IDLE already issues address 0 so bin 0 lands two edges after the frame fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rcnt   <= '0;
            rbank  <= 1'b0;
            full   <= '0;
            rd_vld <= 1'b0;
            rd_sof <= 1'b0;
        end else begin
            full   <= full_nxt_c;
            rd_vld <= rd_go_c;
            rd_sof <= rd_go_c && (rcnt == '0);
            case (state)
                IDLE: begin
                    if (full[rbank]) begin
                        state <= READ;
                        rcnt  <= rcnt + 1'b1;
                    end
                end
                READ: begin
                    if (rd_done_c) begin
                        rcnt  <= '0;
                        rbank <= ~rbank;
                        state <= full[!rbank] ? READ : IDLE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fft_reorder_ram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk  (clk),
        .we   (din_valid),
        .waddr(waddr_c),
        .wdata(din),
        .re   (rd_go_c),
        .raddr(raddr_c),
        .rdata(rdata)
    );

`ifdef FFT_REORDER_SCALE_EN
    // Round-half-up arithmetic shift; one guard bit keeps the +half from wrapping.
    function automatic logic [DBW-1:0] scale(input logic [DBW-1:0] x);
        logic signed [DBW:0] t;
        t = signed'({x[DBW-1], x}) + signed'((DBW + 1)'(1 << (CBW - 1)));
        return DBW'(t >>> CBW);
    endfunction

    always_comb begin
        out_c = {scale(rdata[DW-1:DBW]), scale(rdata[DBW-1:0])};
    end
`else
    always_comb begin
        out_c = rdata;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
        end else begin
            dout       <= rd_vld ? out_c : '0;
            dout_valid <= rd_vld;
            dout_sof   <= rd_sof;
        end
    end

endmodule

// File: tb/tb_fft_reorder_8.sv
// Self-checking bench for fft_reorder_8 with a frame-level reorder model.
module tb_fft_reorder_8;
    import fft_pkg::*;

    localparam int N = 8;

    typedef logic [7:0] lit8_t [8];
    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic        sof;
    } ent_t;

`ifdef FFT_REORDER_SCALE_EN
    localparam lit8_t LIT_RAMP  = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    localparam lit8_t LIT_SYNC  = '{8'd5, 8'd6, 8'd5, 8'd6, 8'd5, 8'd6, 8'd5, 8'd6};
    localparam lit8_t LIT_8N4   = '{8'd1, 8'd5, 8'd3, 8'd7, 8'd2, 8'd6, 8'd4, 8'd8};
    localparam lit8_t LIT_NEG12 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    localparam lit8_t LIT_RAMP  = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
    localparam lit8_t LIT_SYNC  = '{8'd40, 8'd44, 8'd42, 8'd46, 8'd41, 8'd45, 8'd43, 8'd47};
    localparam lit8_t LIT_8N4   = '{8'd4, 8'd36, 8'd20, 8'd52, 8'd12, 8'd44, 8'd28, 8'd60};
    localparam lit8_t LIT_NEG12 = '{8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4, 8'hF4};
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_sof = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_sof;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pos = 0;
    logic [15:0] fbuf [N];
    ent_t expq [$];
    ent_t obs [$];

    always #5 clk = ~clk;

    fft_reorder_8 dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_sof  (dout_sof)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    function automatic int brev3(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    function automatic logic [7:0] scl(input logic [7:0] x);
        int t;
        t = int'($signed(x)) + 4;
        t = t >>> 3;
        return 8'(t);
    endfunction

    function automatic logic [15:0] model_out(input logic [15:0] w);
        cplx_t c;
        c = w;
`ifdef FFT_REORDER_SCALE_EN
        c.re = scl(c.re);
        c.im = scl(c.im);
`endif
        return c;
    endfunction

    // Frame model: natural bin b sits at input position bitrev(b); bin b due at edge k+2+b.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pos = 0;
            expq.delete();
        end else if (din_valid) begin
            if (din_sof) pos = 0;
            fbuf[pos] = din;
            if (pos == N - 1) begin
                for (int b = 0; b < N; b++) begin
                    ent_t e;
                    e.cyc = cyc + 2 + b;
                    e.d   = model_out(fbuf[brev3(b)]);
                    e.sof = (b == 0);
                    expq.push_back(e);
                end
                pos = 0;
            end else begin
                pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            check("rst_valid", 32'(dout_valid), 32'd0);
        end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
            ent_t e;
            e = expq.pop_front();
            check("out_valid", 32'(dout_valid), 32'd1);
            check("out_sof", 32'(dout_sof), 32'(e.sof));
            check("out_data", 32'(dout), 32'(e.d));
        end else begin
            check("idle_valid", 32'(dout_valid), 32'd0);
        end
        if (dout_valid) begin
            ent_t o;
            o.cyc = cyc;
            o.d   = dout;
            o.sof = dout_sof;
            obs.push_back(o);
        end
    end

    task automatic drv(input logic [15:0] d, input logic v, input logic s);
        din       = d;
        din_valid = v;
        din_sof   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(16'd0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string nm);
        idle(N + 6);
        check(nm, 32'(expq.size()), 32'd0);
    endtask

    task automatic pin(input string nm, input lit8_t lit);
        check({nm, "_count"}, 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check(nm, (i < obs.size()) ? {24'd0, obs[i].d[7:0]} : 32'hFFFF_FFFF, {24'd0, lit[i]});
        end
    endtask

    initial begin
        int last;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_sof", 32'(dout_sof), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Ramp real=n, one contiguous frame
        obs.delete();
        for (int n = 0; n < N; n++) drv({8'd0, 8'(n)}, 1'b1, n == 0);
        last = cyc;
        drain("ramp_drain");
        check("ramp_latency", (obs.size() > 0) ? 32'(obs[0].cyc - last) : 32'hFFFF_FFFF, 32'd2);
        check("ramp_first_sof", (obs.size() > 0) ? 32'(obs[0].sof) : 32'hFFFF_FFFF, 32'd1);
        pin("ramp_vals", LIT_RAMP);

        // Three back-to-back frames
        obs.delete();
        for (int n = 0; n < 3 * N; n++) drv(16'($urandom), 1'b1, (n % N) == 0);
        drain("b2b_drain");
        check("b2b_count", 32'(obs.size()), 32'd24);
        check("b2b_span", (obs.size() == 24) ? 32'(obs[23].cyc - obs[0].cyc) : 32'hFFFF_FFFF, 32'd23);

        // Same ramp with two idle cycles between samples
        obs.delete();
        for (int n = 0; n < N; n++) begin
            drv({8'd0, 8'(n)}, 1'b1, n == 0);
            if (n < N - 1) idle(2);
        end
        last = cyc;
        drain("gap_drain");
        check("gap_latency", (obs.size() > 0) ? 32'(obs[0].cyc - last) : 32'hFFFF_FFFF, 32'd2);
        pin("gap_vals", LIT_RAMP);

        // Resync: 5 abandoned samples then sof restarts the frame
        obs.delete();
        for (int n = 0; n < 5; n++) drv({8'd0, 8'(100 + n)}, 1'b1, n == 0);
        for (int n = 0; n < N; n++) drv({8'(n), 8'(40 + n)}, 1'b1, n == 0);
        drain("sync_drain");
        pin("sync_vals", LIT_SYNC);

        // Reset during readout at bin 3, with a partial next frame in flight
        for (int n = 0; n < N; n++) drv({8'd0, 8'(16 + n)}, 1'b1, n == 0);
        for (int n = 0; n < 3; n++) drv({8'd0, 8'(90 + n)}, 1'b1, n == 0);
        din_valid = 1'b0;
        din_sof   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_pre_valid", 32'(dout_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_dout", 32'(dout), 32'd0);
        check("rst_async_valid", 32'(dout_valid), 32'd0);
        check("rst_async_sof", 32'(dout_sof), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // First frame after reset, no sof: real = 8n+4
        obs.delete();
        for (int n = 0; n < N; n++) drv({8'(n), 8'(8 * n + 4)}, 1'b1, 1'b0);
        drain("post_rst_drain");
        pin("post_rst_vals", LIT_8N4);

        // Negative values: real = -12
        obs.delete();
        for (int n = 0; n < N; n++) drv({8'(3 * n), 8'hF4}, 1'b1, n == 0);
        drain("neg_drain");
        pin("neg_vals", LIT_NEG12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
